// File: rtl/decoder_pkg.sv
// Shared types and decode function for decoder_pipe.
// Widths are sized for the largest supported code; instances use the low NUM_OUT select bits.
package decoder_pkg;

    localparam int unsigned MAX_IN_W = 6;
    localparam int unsigned SEL_W    = 1 << MAX_IN_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [MAX_IN_W-1:0] code;
        logic                act_low;
    } dec_req_t;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             err;
    } dec_rsp_t;

    // Select bits at or above num_out are always zero so unused lanes stay constant.
    function automatic dec_rsp_t decode_f(input dec_req_t req, input int unsigned num_out);
        dec_rsp_t         rsp;
        logic [SEL_W-1:0] hot;
        logic [SEL_W-1:0] mask;
        rsp.err = (32'(req.code) >= num_out);
        hot     = rsp.err ? '0 : (SEL_W'(1) << req.code);
        // A shift by SEL_W wraps to zero, so the subtraction yields all ones for a full decoder.
        mask    = (SEL_W'(1) << num_out) - SEL_W'(1);
        rsp.sel = (req.act_low ? ~hot : hot) & mask;
        return rsp;
    endfunction

endpackage

// File: rtl/decoder_skid_buf.sv
// Two-entry valid/ready skid buffer: registered output stage plus one overflow slot.
// in_ready_o is registered and never depends combinationally on out_ready_i.
module decoder_skid_buf
    import decoder_pkg::*;
#(
    parameter type T = dec_rsp_t
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    pipe_state_e state_q, state_d;
    T            out_q, out_d;
    T            skid_q, skid_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q, in_ready_d;
    logic        accept_c;
    logic        emit_c;

    assign accept_c = in_valid_i && in_ready_q;
    assign emit_c   = out_valid_q && out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Output register is cleared when it drains so the select vector reads zero while idle.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept_c) begin
                    state_d = ST_ONE;
                    out_d   = in_data_i;
                end
            end
            ST_ONE: begin
                if (accept_c && emit_c) begin
                    out_d = in_data_i;
                end else if (accept_c) begin
                    state_d = ST_TWO;
                    skid_d  = in_data_i;
                end else if (emit_c) begin
                    state_d = ST_EMPTY;
                    out_d   = '0;
                end
            end
            ST_TWO: begin
                if (emit_c) begin
                    state_d = ST_ONE;
                    out_d   = skid_q;
                    skid_d  = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                out_d   = '0;
                skid_d  = '0;
            end
        endcase
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_q;

endmodule

// File: rtl/decoder_pipe.sv
// Registered binary-to-one-hot/one-cold decoder with valid/ready streams and a 2-entry skid.
// Optional saturating accept/error counters are built when DECODER_STATS_EN is defined.
module decoder_pipe
    import decoder_pkg::*;
#(
    parameter int unsigned IN_W    = 3,
    parameter int unsigned NUM_OUT = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_code,
    input  logic               in_act_low,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_sel,
    output logic               out_err
`ifdef DECODER_STATS_EN
    ,
    output logic [CNT_W-1:0]   stat_accept_cnt,
    output logic [CNT_W-1:0]   stat_err_cnt
`endif
);

    if (IN_W < 1 || IN_W > MAX_IN_W || NUM_OUT < 1 || NUM_OUT > (1 << IN_W) || CNT_W < 1)
    begin : g_bad_cfg
        $error("decoder_pipe: unsupported IN_W/NUM_OUT/CNT_W combination");
    end

    dec_req_t req_c;
    dec_rsp_t rsp_c;
    dec_rsp_t out_rsp;

    assign req_c.code    = MAX_IN_W'(in_code);
    assign req_c.act_low = in_act_low;
    assign rsp_c         = decode_f(req_c, NUM_OUT);

    // Decode happens before the skid, so both stored entries already carry their final select word.
    decoder_skid_buf #(
        .T (dec_rsp_t)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (rsp_c),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_rsp)
    );

    assign out_sel = out_rsp.sel[NUM_OUT-1:0];
    assign out_err = out_rsp.err;

    if (NUM_OUT < SEL_W) begin : g_sel_hi
        logic unused_sel_hi;
        assign unused_sel_hi = |out_rsp.sel[SEL_W-1:NUM_OUT];
    end

`ifdef DECODER_STATS_EN
    logic             accept_c;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign accept_c = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            acc_cnt_q <= acc_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Counted at accept time; both counters stick at all-ones.
    always_comb begin
        acc_cnt_d = acc_cnt_q;
        err_cnt_d = err_cnt_q;
        if (accept_c) begin
            if (acc_cnt_q != {CNT_W{1'b1}}) begin
                acc_cnt_d = acc_cnt_q + CNT_W'(1);
            end
            if (rsp_c.err && (err_cnt_q != {CNT_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stat_accept_cnt = acc_cnt_q;
    assign stat_err_cnt    = err_cnt_q;
`endif

endmodule
